// File: rtl/scan_addr_pkg.sv
// Shared types and defaults for the 2D strided address scan controller.
package scan_addr_pkg;

    localparam int SCAN_AW  = 32;
    localparam int SCAN_XSW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic [SCAN_AW-1:0]  offset;
        logic [SCAN_AW-1:0]  x_max;
        logic [SCAN_AW-1:0]  y_max;
        logic [SCAN_XSW-1:0] x_stride;
        logic [SCAN_AW-1:0]  y_stride;
    } scan_cfg_t;

endpackage

// File: rtl/scan_xy_counter.sv
// x/y position counters for the scan; reports row wrap, last position and the
// position that the next advance will move to.
module scan_xy_counter #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    input  logic [AW-1:0] x_max,
    input  logic [AW-1:0] y_max,
    output logic          row_wrap,
    output logic          is_last,
    output logic [AW-1:0] next_x,
    output logic [AW-1:0] next_y
);

    logic [AW-1:0] x_q, x_d;
    logic [AW-1:0] y_q, y_d;

    assign row_wrap = (x_q == x_max);
    assign is_last  = row_wrap && (y_q == y_max);
    assign next_x   = row_wrap ? '0 : x_q + AW'(1);
    assign next_y   = row_wrap ? y_q + AW'(1) : y_q;

    // clear wins over advance so a fresh job always starts at the origin
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            x_d = next_x;
            y_d = next_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/scan_addr_ctrl.sv
// Sequences one 2D strided address scan per accepted descriptor, with
// valid/ready backpressure, last-beat marking, a done pulse and abort.
module scan_addr_ctrl
    import scan_addr_pkg::*;
#(
    parameter int AW  = SCAN_AW,
    parameter int XSW = SCAN_XSW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [AW-1:0]  cfg_offset,
    input  logic [AW-1:0]  cfg_x_max,
    input  logic [AW-1:0]  cfg_y_max,
    input  logic [XSW-1:0] cfg_x_stride,
    input  logic [AW-1:0]  cfg_y_stride,
    input  logic           abort,
    output logic           addr_valid,
    input  logic           addr_ready,
    output logic [AW-1:0]  addr,
    output logic           addr_last,
    output logic           busy,
    output logic           done
);

    scan_state_e    state_q, state_d;
    logic [AW-1:0]  offset_q, offset_d;
    logic [AW-1:0]  x_max_q, x_max_d;
    logic [AW-1:0]  y_max_q, y_max_d;
    logic [XSW-1:0] x_stride_q, x_stride_d;
    logic [AW-1:0]  y_stride_q, y_stride_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           vld_q, vld_d;
    logic           last_q, last_d;

    logic           accept;
    logic           xfer;
    logic           step;
    logic           row_wrap;
    logic           is_last;
    logic [AW-1:0]  next_x;
    logic [AW-1:0]  next_y;
    logic [AW-1:0]  acc_next;

    assign accept = (state_q == IDLE) && cfg_valid;
    assign xfer   = (state_q == RUN) && vld_q && addr_ready;
    // an aborted transfer is consumed but never advances the scan
    assign step   = xfer && !abort && !is_last;

    assign acc_next = row_wrap ? acc_q + y_stride_q : acc_q + AW'(x_stride_q);

    scan_xy_counter #(
        .AW(AW)
    ) u_xy (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .advance  (step),
        .x_max    (x_max_q),
        .y_max    (y_max_q),
        .row_wrap (row_wrap),
        .is_last  (is_last),
        .next_x   (next_x),
        .next_y   (next_y)
    );

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        x_max_d    = x_max_q;
        y_max_d    = y_max_q;
        x_stride_d = x_stride_q;
        y_stride_d = y_stride_q;
        acc_d      = acc_q;
        addr_d     = addr_q;
        vld_d      = vld_q;
        last_d     = last_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    offset_d   = cfg_offset;
                    x_max_d    = cfg_x_max;
                    y_max_d    = cfg_y_max;
                    x_stride_d = cfg_x_stride;
                    y_stride_d = cfg_y_stride;
                    acc_d      = '0;
                    addr_d     = cfg_offset;
                    last_d     = (cfg_x_max == '0) && (cfg_y_max == '0);
                    vld_d      = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else if (xfer) begin
                    if (is_last) begin
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        acc_d  = acc_next;
                        addr_d = offset_q + acc_next;
                        last_d = (next_x == x_max_q) && (next_y == y_max_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            offset_q   <= '0;
            x_max_q    <= '0;
            y_max_q    <= '0;
            x_stride_q <= '0;
            y_stride_q <= '0;
            acc_q      <= '0;
            addr_q     <= '0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            x_max_q    <= x_max_d;
            y_max_q    <= y_max_d;
            x_stride_q <= x_stride_d;
            y_stride_q <= y_stride_d;
            acc_q      <= acc_d;
            addr_q     <= addr_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
        end
    end

    assign cfg_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign addr_valid = vld_q;
    assign addr       = addr_q;
    assign addr_last  = last_q;

endmodule

// File: tb/tb_scan_addr_ctrl.sv
// Self-checking bench for scan_addr_ctrl: descriptor table, randomized jobs
// against a closed-form address model, plus reset/abort sequences.
module tb_scan_addr_ctrl;
    import scan_addr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_offset;
    logic [31:0] cfg_x_max;
    logic [31:0] cfg_y_max;
    logic [15:0] cfg_x_stride;
    logic [31:0] cfg_y_stride;
    logic        abort;
    logic        addr_valid;
    logic        addr_ready;
    logic [31:0] addr;
    logic        addr_last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scan_addr_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_offset   (cfg_offset),
        .cfg_x_max    (cfg_x_max),
        .cfg_y_max    (cfg_y_max),
        .cfg_x_stride (cfg_x_stride),
        .cfg_y_stride (cfg_y_stride),
        .abort        (abort),
        .addr_valid   (addr_valid),
        .addr_ready   (addr_ready),
        .addr         (addr),
        .addr_last    (addr_last),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        scan_cfg_t   cfg;
        int          ready_mode;
        int          abort_at;
        int          exp_beats;
        logic [31:0] exp_last_addr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic scan_cfg_t mk_cfg(input logic [31:0] o, input logic [31:0] xm,
                                         input logic [31:0] ym, input logic [15:0] xs,
                                         input logic [31:0] ys);
        scan_cfg_t c;
        c.offset   = o;
        c.x_max    = xm;
        c.y_max    = ym;
        c.x_stride = xs;
        c.y_stride = ys;
        return c;
    endfunction

    // Beat i sits at column i mod (x_max+1), row i div (x_max+1); a whole row
    // advances the pointer by x_max*x_stride + y_stride.
    function automatic logic [31:0] model_addr(input scan_cfg_t c, input int i);
        logic [31:0] w, xx, yy, xs, row_step;
        w        = c.x_max + 32'd1;
        xx       = 32'(i) % w;
        yy       = 32'(i) / w;
        xs       = {16'h0, c.x_stride};
        row_step = c.x_max * xs + c.y_stride;
        return c.offset + yy * row_step + xx * xs;
    endfunction

    function automatic bit ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Runs one job from descriptor handshake to return to idle, checking every
    // beat, stall stability and the done/abort epilogue.
    task automatic run_job(input scan_cfg_t c, input int ready_mode, input int abort_at,
                           input bit hold_cfg, output int nb, output logic [31:0] last_a);
        int          n;
        int          cyc;
        int          k;
        bit          rdy;
        bit          stalled;
        bit          aborted;
        bit          finished;
        logic [31:0] st_addr;
        logic        st_last;

        n        = (int'(c.x_max) + 1) * (int'(c.y_max) + 1);
        nb       = 0;
        last_a   = 'x;
        stalled  = 1'b0;
        aborted  = 1'b0;
        finished = 1'b0;
        st_addr  = '0;
        st_last  = 1'b0;

        @(negedge clk);
        k = 0;
        while (!cfg_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!cfg_ready) begin
            chk("start_timeout", 32'(cfg_ready), 32'd1);
            return;
        end
        cfg_offset   = c.offset;
        cfg_x_max    = c.x_max;
        cfg_y_max    = c.y_max;
        cfg_x_stride = c.x_stride;
        cfg_y_stride = c.y_stride;
        cfg_valid    = 1'b1;
        @(negedge clk);
        if (!hold_cfg) cfg_valid = 1'b0;
        chk("first_vld", 32'(addr_valid), 32'd1);
        chk("busy_run", 32'(busy), 32'd1);
        chk("cfg_rdy_run", 32'(cfg_ready), 32'd0);

        cyc = 0;
        while (!finished && cyc < 400) begin
            if (stalled && addr_valid) begin
                chk("stall_addr", addr, st_addr);
                chk("stall_last", 32'(addr_last), 32'(st_last));
            end
            rdy        = ready_for(ready_mode, cyc);
            addr_ready = rdy;
            abort      = (nb == abort_at) && rdy && addr_valid;
            if (addr_valid && rdy) begin
                chk($sformatf("addr[%0d]", nb), addr, model_addr(c, nb));
                chk($sformatf("last[%0d]", nb), 32'(addr_last), 32'(nb == n - 1));
                last_a = addr;
                if (abort) begin
                    aborted  = 1'b1;
                    finished = 1'b1;
                end else if (nb >= n - 1) begin
                    finished = 1'b1;
                end
                nb++;
            end
            stalled = addr_valid && !rdy;
            st_addr = addr;
            st_last = addr_last;
            @(negedge clk);
            abort = 1'b0;
            cyc++;
        end
        addr_ready = 1'b0;
        cfg_valid  = 1'b0;
        if (!finished) begin
            chk("job_timeout", 32'(finished), 32'd1);
            return;
        end

        if (aborted) begin
            chk("abort_vld", 32'(addr_valid), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_cfg_rdy", 32'(cfg_ready), 32'd1);
            @(negedge clk);
            chk("abort_done2", 32'(done), 32'd0);
        end else begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_vld", 32'(addr_valid), 32'd0);
            chk("done_cfg_rdy", 32'(cfg_ready), 32'd0);
            @(negedge clk);
            chk("done_clear", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_cfg_rdy", 32'(cfg_ready), 32'd1);
        end
    endtask

    vec_t        vecs[6];
    int          nb;
    logic [31:0] la;
    scan_cfg_t   rc;
    int          ab;

    initial begin
        rst_n        = 1'b0;
        cfg_valid    = 1'b0;
        cfg_offset   = '0;
        cfg_x_max    = '0;
        cfg_y_max    = '0;
        cfg_x_stride = '0;
        cfg_y_stride = '0;
        abort        = 1'b0;
        addr_ready   = 1'b0;

        vecs[0] = '{mk_cfg(32'h1000, 32'd2, 32'd1, 16'd4, 32'd100), 0, -1, 6, 32'h1074};
        vecs[1] = '{mk_cfg(32'h1000, 32'd2, 32'd1, 16'd4, 32'd100), 1, -1, 6, 32'h1074};
        vecs[2] = '{mk_cfg(32'h40, 32'd0, 32'd0, 16'd4, 32'd100), 0, -1, 1, 32'h40};
        vecs[3] = '{mk_cfg(32'hFFFF_FFFC, 32'd1, 32'd0, 16'd8, 32'd0), 0, -1, 2, 32'h4};
        vecs[4] = '{mk_cfg(32'h200, 32'd0, 32'd2, 16'd7, 32'h10), 1, -1, 3, 32'h220};
        vecs[5] = '{mk_cfg(32'h1000, 32'd2, 32'd1, 16'd4, 32'd100), 0, 2, 3, 32'h1008};

        repeat (3) @(negedge clk);
        chk("rst_addr", addr, 32'h0);
        chk("rst_vld", 32'(addr_valid), 32'd0);
        chk("rst_last", 32'(addr_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cfg_rdy", 32'(cfg_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].cfg, vecs[i].ready_mode, vecs[i].abort_at, 1'b0, nb, la);
            chk($sformatf("vec%0d_beats", i), 32'(nb), 32'(vecs[i].exp_beats));
            chk($sformatf("vec%0d_last_addr", i), la, vecs[i].exp_last_addr);
        end

        // descriptor held high while busy must not restart the scan
        run_job(vecs[0].cfg, 2, -1, 1'b1, nb, la);
        chk("hold_beats", 32'(nb), 32'd6);

        // reset mid-job: clears outputs asynchronously, then a fresh job runs
        @(negedge clk);
        cfg_offset   = 32'h1000;
        cfg_x_max    = 32'd2;
        cfg_y_max    = 32'd1;
        cfg_x_stride = 16'd4;
        cfg_y_stride = 32'd100;
        cfg_valid    = 1'b1;
        addr_ready   = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("mid_beat2", addr, 32'h1004);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_addr", addr, 32'h0);
        chk("mrst_vld", 32'(addr_valid), 32'd0);
        chk("mrst_last", 32'(addr_last), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        addr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_cfg_rdy", 32'(cfg_ready), 32'd1);
        run_job(vecs[0].cfg, 0, -1, 1'b0, nb, la);
        chk("mrst_job_beats", 32'(nb), 32'd6);

        for (int j = 0; j < 24; j++) begin
            rc = mk_cfg($urandom, 32'($urandom_range(0, 4)), 32'($urandom_range(0, 3)),
                        16'($urandom_range(0, 65535)), $urandom);
            ab = ($urandom_range(0, 3) == 0)
                 ? int'($urandom_range(0, (int'(rc.x_max) + 1) * (int'(rc.y_max) + 1) - 1))
                 : -1;
            run_job(rc, int'($urandom_range(0, 2)), ab, 1'b0, nb, la);
            chk($sformatf("rnd%0d_beats", j), 32'(nb),
                (ab >= 0) ? 32'(ab + 1) : 32'((int'(rc.x_max) + 1) * (int'(rc.y_max) + 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_addr_ctrl.md
Name: scan_addr_ctrl

Overview:
- Controller that sequences one 2D strided address scan per accepted configuration.
- Sits between a command source (config handshake) and a memory port (address stream with valid/ready backpressure).
- Replaces free-running scan counters with start/stop, backpressure, last-beat marking, completion and abort.
- Emits (x_max+1)*(y_max+1) addresses per job, then returns to idle.

Parameters:
- AW, 32, width of address, offset, x_max, y_max, y_stride.
- XSW, 16, width of x_stride; zero-extended to AW.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  job descriptor valid
- cfg_ready  out  1  controller can accept a descriptor
- cfg_offset  in  AW  base address
- cfg_x_max  in  AW  last x index (inclusive)
- cfg_y_max  in  AW  last y index (inclusive)
- cfg_x_stride  in  XSW  accumulator increment within a row
- cfg_y_stride  in  AW  accumulator increment on row wrap (replaces x_stride on that step)
- abort  in  1  cancel the running job
- addr_valid  out  1  addr holds a valid beat
- addr_ready  in  1  consumer accepts the beat
- addr  out  AW  offset + acc
- addr_last  out  1  current beat is the final beat of the job
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last beat transfers

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE; x=0, y=0, acc=0.
  - addr=0, addr_valid=0, addr_last=0, done=0, busy=0.
  - Latched config cleared to 0.
- States and transitions:
  - IDLE: cfg_ready=1. On cfg_valid&cfg_ready:
    - latch all cfg_* fields; x=0, y=0, acc=0;
    - addr<=cfg_offset; addr_last<=(cfg_x_max==0 && cfg_y_max==0);
    - addr_valid<=1; go RUN.
    - First beat is visible the cycle after acceptance.
  - RUN: cfg_ready=0. A beat transfers on addr_valid&addr_ready.
    - On transfer of a non-last beat:
      - if x==x_max: x<=0, y<=y+1, acc<=acc+y_stride;
      - else: x<=x+1, acc<=acc+zext(x_stride).
      - addr<=offset+next_acc; addr_last<=(next_x==x_max && next_y==y_max).
    - On transfer of the last beat: addr_valid<=0; go DONE.
    - No transfer: addr, addr_last, x, y, acc all hold. addr is stable while addr_valid=1 && !addr_ready.
  - DONE: done=1 for exactly one cycle, addr_valid=0; go IDLE. cfg_ready returns high the following cycle.
- Throughput: one beat per cycle with addr_ready held high. No bubbles between rows.
- Arithmetic:
  - acc and addr are modulo 2^AW; wrap silently, no flag.
  - x_stride is zero-extended.
  - x==x_max and y==y_max use unsigned equality.
- Abort:
  - Sampled only in RUN. Next state is IDLE; addr_valid<=0, addr_last<=0; no done pulse.
  - If abort and a transfer occur in the same cycle, the beat counts as consumed, but nothing further is emitted.
  - abort in IDLE or DONE is ignored.
- A descriptor presented while busy is not accepted (cfg_ready=0). The source must hold it.
- rst_n asserted mid-job: immediate return to reset values; the job is lost.
- Degenerate cases:
  - x_max=y_max=0 yields exactly one beat with addr_last=1.
  - x_max=0 makes every step a row step (y_stride used).

Decomposition:
- Package scan_addr_pkg: state enum {IDLE, RUN, DONE}; AW/XSW default constants; packed struct scan_cfg_t {offset, x_max, y_max, x_stride, y_stride}.
- Sub-module scan_xy_counter: x/y counters with advance enable. Outputs row_wrap (x==x_max), is_last, next_x, next_y. The controller owns acc, addr and the FSM.

Test Plan:
- Basic job, addr_ready=1: offset=0x1000, x_max=2, y_max=1, x_stride=4, y_stride=100
  - -> addr 0x1000, 0x1004, 0x1008, 0x106C, 0x1070, 0x1074 on consecutive cycles;
  - -> addr_last only on 0x1074; done one cycle later; cfg_ready high the cycle after done.
- Backpressure: same job, addr_ready toggled 1,0,0,1,...
  - -> identical address sequence; addr/addr_last stable during stalls; exactly 6 transfers.
- Single beat: x_max=0, y_max=0, offset=0x40 -> one beat 0x40 with addr_last=1; done; busy low after 2 cycles.
- Wrap-around: offset=0xFFFFFFFC, x_max=1, y_max=0, x_stride=8 -> 0xFFFFFFFC, then 0x00000004 (last).
- Abort: start the basic job, assert abort on the 3rd beat with addr_ready=1
  - -> beats 0x1000, 0x1004, 0x1008 transfer; addr_valid=0 next cycle; no done; new descriptor accepted immediately.
- Reset mid-job: deassert rst_n during beat 2 -> all outputs 0 asynchronously; after release, cfg_ready=1 and a new job runs from x=0, y=0.
